sd_source: RTL and testbench
============================

// Module: sd_source
//
// PURPOSE
//  Sideband source for the TX sideband path: generates one sideband packet per upstream trigger.
//  Packet fields: ante/exp/symbol/slot/frame. Traffic is valid/ready, in the same format sd_forward consumes.
//  Sits on clk_wr ahead of sd_forward: dout_* drives din_*, and din_ready drives dout_ready.
//  Maintains cascaded antenna/symbol/slot/frame indices and absorbs one-deep trigger backlog.
//
// PARAMETERS
//  PKT_LEN     4     beats per sideband packet, >=1
//  BEAT_WIDTH  2     beat counter width, holds PKT_LEN-1
//  ANTE_QTY    4     antennas per symbol, <=4
//  SYMBOL_QTY  14    symbols per slot, <=16
//  SLOT_QTY    20    slots per frame, <=256
//  FRAME_QTY   1024  frames before wrap, <=1024
//
// PORTS
//  clk_wr       in   1   write clock, posedge active
//  rst_n        in   1   reset, asynchronous, active-low
//  enable       in   1   level; 1 = accept triggers
//  restart      in   1   pulse; reload indices from init_*
//  init_symbol  in   4   restart symbol value
//  init_slot    in   8   restart slot value
//  init_frame   in   10  restart frame value
//  trig         in   1   pulse; request one packet
//  exp_in       in   6   exponent, sampled with trig
//  dout_ready   in   1   downstream ready (sd_forward din_ready)
//  dout_valid   out  1   output beat valid
//  dout_sop     out  1   first beat of packet
//  dout_eop     out  1   last beat of packet
//  dout_ante    out  2   antenna index
//  dout_exp     out  6   exponent
//  dout_symbol  out  4   symbol index
//  dout_slot    out  8   slot index
//  dout_frame   out  10  frame index
//  busy         out  1   state != IDLE
//  drop_cnt     out  32  dropped-trigger count
//
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, indices 0, pending 0.
//  - All outputs are registered.
//  - FSM states:
//    - IDLE: trig ignored and not counted. enable=1 -> ARMED.
//    - ARMED: trig -> capture exp_in, go to SEND. dout_valid=1 and sop=1 the cycle after trig (latency 1).
//      enable=0 -> IDLE.
//    - SEND: beat advances only on dout_valid&dout_ready.
//      - sop=1 at beat 0; eop=1 at beat PKT_LEN-1. PKT_LEN=1 gives sop=eop on the same beat.
//      - Fields are constant for the whole packet. Output holds while dout_ready=0.
//  - On eop accepted:
//    - Indices advance: ante wraps at ANTE_QTY-1 and carries into symbol; symbol->slot; slot->frame.
//      Frame wraps FRAME_QTY-1 -> 0.
//    - If a trigger is pending (or trig arrives the same cycle), the next packet starts with no bubble:
//      sop on the next cycle with the new exp.
//    - Otherwise, with enable=1 -> ARMED; with enable=0 -> IDLE.
//  - trig during SEND:
//    - No pending: pending<=1, pend_exp<=exp_in.
//    - Pending already set: drop_cnt+1 (wraps at 2^32).
//    - trig in the eop-accept cycle counts as the next start, not a drop.
//  - enable falling mid-packet: the current packet completes untruncated, pending is cleared, then IDLE.
//  - restart:
//    - In IDLE/ARMED: indices <= {0, init_symbol, init_slot, init_frame} on the next edge.
//    - In SEND: deferred to the eop accept. Reload replaces the increment; the in-flight packet is unchanged.
//    - restart and trig in the same ARMED cycle: the packet uses the reloaded indices.
//  - Reset mid-packet: immediate return to reset values. No eop is emitted.
//
// STRUCTURE
//  - Package sd_pkg:
//    - width localparams ANTE_W=2, EXP_W=6, SYM_W=4, SLOT_W=8, FRAME_W=10.
//    - typedef struct packed sd_info_t {ante, exp, symbol, slot, frame}.
//    - typedef enum sd_state_t {IDLE, ARMED, SEND}.
//  - Sub-module sd_index_cnt: cascaded wrap counter.
//    - Inputs: inc, load, init values.
//    - Outputs: current ante/symbol/slot/frame.
//  - Top holds the FSM, beat counter, pending register and drop_cnt.
//
// TESTING
//  1. Reset, enable=1, trig with exp_in=5, ready=1:
//     4 beats, sop on beat 0, eop on beat 3, {ante,sym,slot,frame}={0,0,0,0}, exp=5; next packet ante=1.
//  2. 4*14*20*1024 triggers: frame reaches 1023, slot 19, symbol 13, ante 3, then all indices wrap to 0.
//  3. ready=0 for 10 cycles mid-packet: valid held, fields and beat position frozen, no beat lost.
//  4. 3 triggers during one packet: drop_cnt=1; second packet follows eop with no idle cycle and carries the second trig's exp.
//  5. restart with init_slot=7, init_frame=100 during SEND: current packet unchanged; next packet slot=7, frame=100, ante=0.
//  6. enable=0 at beat 1: packet completes through eop, pending is discarded, busy=0 one cycle after eop accept.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared widths, packet info layout and FSM states for the sideband source.
package sd_pkg;

  localparam int ANTE_W  = 2;
  localparam int EXP_W   = 6;
  localparam int SYM_W   = 4;
  localparam int SLOT_W  = 8;
  localparam int FRAME_W = 10;

  typedef struct packed {
    logic [ANTE_W-1:0]  ante;
    logic [EXP_W-1:0]   exp;
    logic [SYM_W-1:0]   symbol;
    logic [SLOT_W-1:0]  slot;
    logic [FRAME_W-1:0] frame;
  } sd_info_t;

  typedef enum logic [1:0] {IDLE, ARMED, SEND} sd_state_t;

endpackage

// File: rtl/sd_source_if.sv
// Valid/ready sideband beat bus; master drives beats, slave returns ready.
interface sd_source_if;

  logic             valid;
  logic             ready;
  logic             sop;
  logic             eop;
  sd_pkg::sd_info_t info;

  modport master (output valid, sop, eop, info, input ready);
  modport slave  (input valid, sop, eop, info, output ready);

endinterface

// File: rtl/sd_index_cnt.sv
// Cascaded antenna/symbol/slot/frame counter; load wins over inc.
module sd_index_cnt
  import sd_pkg::*;
#(
  parameter int ANTE_QTY   = 4,
  parameter int SYMBOL_QTY = 14,
  parameter int SLOT_QTY   = 20,
  parameter int FRAME_QTY  = 1024
) (
  input  logic               clk_wr,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               load,
  input  logic [SYM_W-1:0]   init_symbol,
  input  logic [SLOT_W-1:0]  init_slot,
  input  logic [FRAME_W-1:0] init_frame,
  output logic [ANTE_W-1:0]  ante,
  output logic [SYM_W-1:0]   symbol,
  output logic [SLOT_W-1:0]  slot,
  output logic [FRAME_W-1:0] frame
);

  localparam logic [ANTE_W-1:0]  ANTE_MAX  = ANTE_W'(ANTE_QTY - 1);
  localparam logic [SYM_W-1:0]   SYM_MAX   = SYM_W'(SYMBOL_QTY - 1);
  localparam logic [SLOT_W-1:0]  SLOT_MAX  = SLOT_W'(SLOT_QTY - 1);
  localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(FRAME_QTY - 1);

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      ante   <= '0;
      symbol <= '0;
      slot   <= '0;
      frame  <= '0;
    end else if (load) begin
      ante   <= '0;
      symbol <= init_symbol;
      slot   <= init_slot;
      frame  <= init_frame;
    end else if (inc) begin
      ante <= (ante == ANTE_MAX) ? '0 : ante + ANTE_W'(1);
      if (ante == ANTE_MAX) begin
        symbol <= (symbol == SYM_MAX) ? '0 : symbol + SYM_W'(1);
        if (symbol == SYM_MAX) begin
          slot <= (slot == SLOT_MAX) ? '0 : slot + SLOT_W'(1);
          if (slot == SLOT_MAX)
            frame <= (frame == FRAME_MAX) ? '0 : frame + FRAME_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sd_source.sv
// Sideband packet source: one PKT_LEN-beat packet per trigger, one-deep trigger backlog.
// Indices live in the counter and only move on eop accept, so they double as the packet fields.
module sd_source
  import sd_pkg::*;
#(
  parameter int PKT_LEN    = 4,
  parameter int BEAT_WIDTH = 2,
  parameter int ANTE_QTY   = 4,
  parameter int SYMBOL_QTY = 14,
  parameter int SLOT_QTY   = 20,
  parameter int FRAME_QTY  = 1024
) (
  input  logic               clk_wr,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               restart,
  input  logic [SYM_W-1:0]   init_symbol,
  input  logic [SLOT_W-1:0]  init_slot,
  input  logic [FRAME_W-1:0] init_frame,
  input  logic               trig,
  input  logic [EXP_W-1:0]   exp_in,
  sd_source_if.master        dout,
  output logic               busy,
  output logic [31:0]        drop_cnt
);

  sd_state_t               state_q, state_d;
  logic [BEAT_WIDTH-1:0]   beat_q, beat_d;
  logic                    pend_q, pend_d;
  logic [EXP_W-1:0]        pend_exp_q, pend_exp_d;
  logic                    restart_q, restart_d;
  logic [EXP_W-1:0]        exp_q, exp_d;
  logic                    vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
  logic                    busy_d;
  logic [31:0]             drop_d;
  logic                    inc, load, fire, start;
  logic [EXP_W-1:0]        start_exp;
  logic [ANTE_W-1:0]       ante;
  logic [SYM_W-1:0]        symbol;
  logic [SLOT_W-1:0]       slot;
  logic [FRAME_W-1:0]      frame;

  sd_index_cnt #(
    .ANTE_QTY(ANTE_QTY), .SYMBOL_QTY(SYMBOL_QTY), .SLOT_QTY(SLOT_QTY), .FRAME_QTY(FRAME_QTY)
  ) u_idx (
    .clk_wr(clk_wr), .rst_n(rst_n), .inc(inc), .load(load),
    .init_symbol(init_symbol), .init_slot(init_slot), .init_frame(init_frame),
    .ante(ante), .symbol(symbol), .slot(slot), .frame(frame)
  );

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      pend_q     <= 1'b0;
      pend_exp_q <= '0;
      restart_q  <= 1'b0;
      exp_q      <= '0;
      vld_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      busy       <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      pend_q     <= pend_d;
      pend_exp_q <= pend_exp_d;
      restart_q  <= restart_d;
      exp_q      <= exp_d;
      vld_q      <= vld_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      busy       <= busy_d;
      drop_cnt   <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    pend_d     = pend_q;
    pend_exp_d = pend_exp_q;
    restart_d  = restart_q;
    exp_d      = exp_q;
    vld_d      = vld_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    drop_d     = drop_cnt;
    inc        = 1'b0;
    load       = 1'b0;
    start      = 1'b0;
    start_exp  = exp_in;
    fire       = vld_q & dout.ready;

    case (state_q)
      IDLE: begin
        load = restart;
        if (enable) state_d = ARMED;
      end
      ARMED: begin
        load = restart;
        if (!enable) state_d = IDLE;
        else if (trig) start = 1'b1;
      end
      SEND: begin
        if (fire && eop_q) begin
          // A deferred restart replaces the increment for the next packet.
          load      = restart_q | restart;
          inc       = !load;
          restart_d = 1'b0;
          if (enable && (pend_q || trig)) begin
            start      = 1'b1;
            start_exp  = pend_q ? pend_exp_q : exp_in;
            pend_d     = pend_q & trig;
            pend_exp_d = exp_in;
          end else begin
            pend_d  = 1'b0;
            vld_d   = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            state_d = enable ? ARMED : IDLE;
          end
        end else begin
          if (restart) restart_d = 1'b1;
          if (fire) begin
            beat_d = beat_q + BEAT_WIDTH'(1);
            sop_d  = 1'b0;
            eop_d  = (32'(beat_q) + 32'd1 == 32'(PKT_LEN - 1));
          end
          if (trig) begin
            if (pend_q) begin
              drop_d = drop_cnt + 32'd1;
            end else begin
              pend_d     = 1'b1;
              pend_exp_d = exp_in;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = SEND;
      vld_d   = 1'b1;
      sop_d   = 1'b1;
      eop_d   = (PKT_LEN == 1);
      beat_d  = '0;
      exp_d   = start_exp;
    end
    busy_d = (state_d != IDLE);
  end

  assign dout.valid = vld_q;
  assign dout.sop   = sop_q;
  assign dout.eop   = eop_q;
  assign dout.info  = '{ante: ante, exp: exp_q, symbol: symbol, slot: slot, frame: frame};

endmodule

// File: tb/tb_sd_source.sv
// Scoreboard bench for sd_source: directed triggers push expected beats, a monitor pops on accept.
module tb_sd_source;
  import sd_pkg::*;

  logic               clk_wr = 1'b0;
  logic               rst_n, enable, restart, trig;
  logic [SYM_W-1:0]   init_symbol;
  logic [SLOT_W-1:0]  init_slot;
  logic [FRAME_W-1:0] init_frame;
  logic [EXP_W-1:0]   exp_in;
  logic               busy;
  logic [31:0]        drop_cnt;

  sd_source_if dout ();

  always #5 clk_wr = ~clk_wr;

  sd_source #(
    .PKT_LEN(4), .BEAT_WIDTH(2), .ANTE_QTY(4), .SYMBOL_QTY(14), .SLOT_QTY(20), .FRAME_QTY(1024)
  ) dut (
    .clk_wr(clk_wr), .rst_n(rst_n), .enable(enable), .restart(restart),
    .init_symbol(init_symbol), .init_slot(init_slot), .init_frame(init_frame),
    .trig(trig), .exp_in(exp_in), .dout(dout), .busy(busy), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic     sop;
    logic     eop;
    sd_info_t info;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_wr);
    #1;
  endtask

  task automatic push_pkt(input int e, input int a, input int s, input int sl, input int f);
    for (int b = 0; b < 4; b++) begin
      beat_t x;
      x.sop         = (b == 0);
      x.eop         = (b == 3);
      x.info.ante   = ANTE_W'(a);
      x.info.exp    = EXP_W'(e);
      x.info.symbol = SYM_W'(s);
      x.info.slot   = SLOT_W'(sl);
      x.info.frame  = FRAME_W'(f);
      exp_q.push_back(x);
    end
  endtask

  task automatic pulse_trig(input int e);
    trig   = 1'b1;
    exp_in = EXP_W'(e);
    step(1);
    trig   = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      step(1);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
    step(1);
  endtask

  always @(negedge clk_wr) begin
    beat_t act, req;
    if (rst_n && dout.valid && dout.ready) begin
      act = '{sop: dout.sop, eop: dout.eop, info: dout.info};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat at %0t: got %0h, expected no beat", $time, act);
      end else begin
        req = exp_q.pop_front();
        chk("beat", 64'(act), 64'(req));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; restart = 1'b0; trig = 1'b0; exp_in = '0;
    init_symbol = '0; init_slot = '0; init_frame = '0;
    dout.ready = 1'b1;
    repeat (3) @(negedge clk_wr);
    chk("rst_valid", 64'(dout.valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_info", 64'({dout.sop, dout.eop, dout.info}), 64'd0);
    step(1);
    rst_n = 1'b1;

    // IDLE ignores triggers entirely
    pulse_trig(3);
    step(3);
    chk("idle_trig_busy", 64'(busy), 64'd0);

    // 1: basic packet, latency one, then ante increments
    enable = 1'b1;
    step(1);
    chk("armed_busy", 64'(busy), 64'd1);
    push_pkt(5, 0, 0, 0, 0);
    pulse_trig(5);
    @(negedge clk_wr);
    chk("lat1_valid_sop", 64'({dout.valid, dout.sop}), 64'b11);
    wait_drain();
    push_pkt(6, 1, 0, 0, 0);
    pulse_trig(6);
    wait_drain();

    // 3: ten-cycle stall on beat 1
    push_pkt(7, 2, 0, 0, 0);
    pulse_trig(7);
    step(1);
    dout.ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_wr);
      chk("stall_hold", 64'({dout.valid, dout.sop, dout.eop, dout.info.exp}), 64'({1'b1, 1'b0, 1'b0, 6'd7}));
    end
    step(1);
    dout.ready = 1'b1;
    wait_drain();

    // 4: start + two triggers mid-packet: one pending, one dropped, no bubble
    push_pkt(8, 3, 0, 0, 0);
    push_pkt(9, 0, 1, 0, 0);
    pulse_trig(8);
    pulse_trig(9);
    pulse_trig(10);
    step(2);
    @(negedge clk_wr);
    chk("no_bubble", 64'({dout.valid, dout.sop, dout.info.exp}), 64'({1'b1, 1'b1, 6'd9}));
    chk("drop_one", 64'(drop_cnt), 64'd1);
    wait_drain();

    // 2: restart near the end of the index space, then wrap everything to zero
    init_symbol = 4'd13; init_slot = 8'd19; init_frame = 10'd1023;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    for (int a = 0; a < 4; a++) begin
      push_pkt(20 + a, a, 13, 19, 1023);
      pulse_trig(20 + a);
      wait_drain();
    end
    push_pkt(24, 0, 0, 0, 0);
    pulse_trig(24);
    wait_drain();

    // 5: restart during SEND takes effect only on the next packet
    init_symbol = 4'd0; init_slot = 8'd7; init_frame = 10'd100;
    push_pkt(30, 1, 0, 0, 0);
    pulse_trig(30);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    wait_drain();
    push_pkt(31, 0, 0, 7, 100);
    pulse_trig(31);
    wait_drain();

    // 6: enable drops at beat 1; packet completes, pending trigger discarded
    push_pkt(40, 1, 0, 7, 100);
    pulse_trig(40);
    step(1);
    enable = 1'b0;
    trig   = 1'b1;
    exp_in = 6'd41;
    step(1);
    trig   = 1'b0;
    step(2);
    @(negedge clk_wr);
    chk("disable_busy", 64'({busy, dout.valid}), 64'b00);
    step(6);
    chk("disable_drop", 64'(drop_cnt), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
